// File: rtl/post_adder_accum.sv
// post_adder_accum: DSP48A1-style post-adder/subtractor with P and carry-out
// register stage and accumulate feedback from the P register.
//
// Optional feature: define ACC_OVF_DETECT_EN to add the ovf_sticky output,
// a flag that latches a carry-out seen while accumulating (Z = P).
//
// PREG=0 makes p combinational. In that mode the P feedback selection reads
// as zero, which keeps the adder free of a combinational loop. The internal P
// register still loads under cep.
module post_adder_accum #(
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1,
    parameter int WIDTH       = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rstp,
    input  logic             cep,
    input  logic             cecarryin,
    input  logic [1:0]       x_sel,
    input  logic [1:0]       z_sel,
    input  logic             sub,
    input  logic             cin,
    input  logic [35:0]      m,
    input  logic [WIDTH-1:0] dab,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] pcin,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] pcout,
    output logic             carryout,
    output logic             carryoutf
`ifdef ACC_OVF_DETECT_EN
    ,
    output logic             ovf_sticky
`endif
);

    logic [WIDTH-1:0] p_reg;
    logic             co_reg;
    logic [WIDTH-1:0] p_fb;
    logic [WIDTH-1:0] m_ext;
    logic [WIDTH-1:0] x_val;
    logic [WIDTH-1:0] z_val;
    logic [WIDTH:0]   cin_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] p_next;
    logic             co_next;

    assign p_fb    = (PREG != 0) ? p_reg : '0;
    assign m_ext   = WIDTH'(m);
    assign cin_ext = {{WIDTH{1'b0}}, cin};

    // X and Z operand multiplexers
    always_comb begin
        x_val = '0;
        z_val = '0;
        case (x_sel)
            2'd0:    x_val = '0;
            2'd1:    x_val = m_ext;
            2'd2:    x_val = p_fb;
            default: x_val = dab;
        endcase
        case (z_sel)
            2'd0:    z_val = '0;
            2'd1:    z_val = pcin;
            2'd2:    z_val = p_fb;
            default: z_val = c;
        endcase
    end

    // Post-adder: carry-in is grouped with X, so subtract removes X+cin from Z
    always_comb begin
        if (sub) begin
            sum = {1'b0, z_val} - ({1'b0, x_val} + cin_ext);
        end else begin
            sum = {1'b0, z_val} + {1'b0, x_val} + cin_ext;
        end
    end

    assign p_next  = sum[WIDTH-1:0];
    assign co_next = sum[WIDTH];

    // P register: async clear, then sync clear, then enabled load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg <= '0;
        end else if (rstp) begin
            p_reg <= '0;
        end else if (cep) begin
            p_reg <= p_next;
        end
    end

    // Carry-out register, shares the P reset but has its own enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            co_reg <= 1'b0;
        end else if (rstp) begin
            co_reg <= 1'b0;
        end else if (cecarryin) begin
            co_reg <= co_next;
        end
    end

`ifdef ACC_OVF_DETECT_EN
    // Sticky overflow: a carry out of an accumulate (Z = P) load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (rstp) begin
            ovf_sticky <= 1'b0;
        end else if (cep && (z_sel == 2'd2) && co_next) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

    assign p         = (PREG != 0) ? p_reg : p_next;
    assign pcout     = p;
    assign carryout  = (CARRYOUTREG != 0) ? co_reg : co_next;
    assign carryoutf = carryout;

endmodule

// File: tb/tb_post_adder_accum.sv
// Bench for post_adder_accum: a registered instance (PREG=1, CARRYOUTREG=1)
// and a combinational instance (PREG=0, CARRYOUTREG=0) share one stimulus
// stream and are compared against an arithmetic reference model.
module tb_post_adder_accum;

    logic        clk;
    logic        rst_n;
    logic        rstp;
    logic        cep;
    logic        cecarryin;
    logic [1:0]  x_sel;
    logic [1:0]  z_sel;
    logic        sub;
    logic        cin;
    logic [35:0] m;
    logic [47:0] dab;
    logic [47:0] c;
    logic [47:0] pcin;

    logic [47:0] p;
    logic [47:0] pcout;
    logic        carryout;
    logic        carryoutf;
    logic [47:0] p_c;
    logic [47:0] pcout_c;
    logic        co_c;
    logic        cof_c;
`ifdef ACC_OVF_DETECT_EN
    logic        ovf;
    logic        ovf_c;
    logic        m_ovf;
    logic        m_ovf_c;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [47:0] m_p;
    logic        m_co;

    post_adder_accum #(.PREG(1), .CARRYOUTREG(1), .WIDTH(48)) u_dut (
        .clk(clk), .rst_n(rst_n), .rstp(rstp), .cep(cep), .cecarryin(cecarryin),
        .x_sel(x_sel), .z_sel(z_sel), .sub(sub), .cin(cin), .m(m), .dab(dab),
        .c(c), .pcin(pcin), .p(p), .pcout(pcout), .carryout(carryout),
        .carryoutf(carryoutf)
`ifdef ACC_OVF_DETECT_EN
        , .ovf_sticky(ovf)
`endif
    );

    post_adder_accum #(.PREG(0), .CARRYOUTREG(0), .WIDTH(48)) u_dut_comb (
        .clk(clk), .rst_n(rst_n), .rstp(rstp), .cep(cep), .cecarryin(cecarryin),
        .x_sel(x_sel), .z_sel(z_sel), .sub(sub), .cin(cin), .m(m), .dab(dab),
        .c(c), .pcin(pcin), .p(p_c), .pcout(pcout_c), .carryout(co_c),
        .carryoutf(cof_c)
`ifdef ACC_OVF_DETECT_EN
        , .ovf_sticky(ovf_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {carry, result} of Z +/- (X + cin), modulo 2^49
    function automatic logic [48:0] ref_sum(input logic [47:0] pfb);
        longint unsigned xv, zv, r;
        case (x_sel)
            2'd0:    xv = 64'd0;
            2'd1:    xv = 64'(m);
            2'd2:    xv = 64'(pfb);
            default: xv = 64'(dab);
        endcase
        case (z_sel)
            2'd0:    zv = 64'd0;
            2'd1:    zv = 64'(pcin);
            2'd2:    zv = 64'(pfb);
            default: zv = 64'(c);
        endcase
        r = sub ? (zv - xv - 64'(cin)) : (zv + xv + 64'(cin));
        return r[48:0];
    endfunction

    task automatic chk_comb(input logic [48:0] e);
        chk("comb_p", 64'(p_c), 64'(e[47:0]));
        chk("comb_pcout", 64'(pcout_c), 64'(e[47:0]));
        chk("comb_co", 64'(co_c), 64'(e[48]));
        chk("comb_cof", 64'(cof_c), 64'(e[48]));
    endtask

    // One clock edge: advance the model, then compare both instances
    task automatic step();
        logic [48:0] n_r;
        logic [48:0] n_c;
        n_r = ref_sum(m_p);
        n_c = ref_sum(48'd0);
        if (rstp) begin
            m_p  = '0;
            m_co = 1'b0;
`ifdef ACC_OVF_DETECT_EN
            m_ovf   = 1'b0;
            m_ovf_c = 1'b0;
`endif
        end else begin
            if (cep) begin
                m_p = n_r[47:0];
`ifdef ACC_OVF_DETECT_EN
                if (z_sel == 2'd2 && n_r[48]) m_ovf = 1'b1;
                if (z_sel == 2'd2 && n_c[48]) m_ovf_c = 1'b1;
`endif
            end
            if (cecarryin) m_co = n_r[48];
        end
        @(posedge clk);
        #1;
        chk("p", 64'(p), 64'(m_p));
        chk("pcout", 64'(pcout), 64'(m_p));
        chk("carryout", 64'(carryout), 64'(m_co));
        chk("carryoutf", 64'(carryoutf), 64'(m_co));
`ifdef ACC_OVF_DETECT_EN
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("ovf_comb", 64'(ovf_c), 64'(m_ovf_c));
`endif
        chk_comb(n_c);
    endtask

    initial begin
        rst_n = 1'b0; rstp = 1'b0; cep = 1'b0; cecarryin = 1'b0;
        x_sel = 2'd0; z_sel = 2'd0; sub = 1'b0; cin = 1'b0;
        m = '0; dab = '0; c = '0; pcin = '0;
        m_p = '0; m_co = 1'b0;
`ifdef ACC_OVF_DETECT_EN
        m_ovf = 1'b0; m_ovf_c = 1'b0;
`endif
        #2;
        chk("rst_p", 64'(p), 64'd0);
        chk("rst_pcout", 64'(pcout), 64'd0);
        chk("rst_carryout", 64'(carryout), 64'd0);
        chk("rst_carryoutf", 64'(carryoutf), 64'd0);
`ifdef ACC_OVF_DETECT_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add: 10 + 5 + 1
        x_sel = 2'd1; z_sel = 2'd3; m = 36'd5; c = 48'd10; cin = 1'b1;
        sub = 1'b0; cep = 1'b1; cecarryin = 1'b1;
        step();
        chk("t1_p", 64'(p), 64'd16);
        chk("t1_co", 64'(carryout), 64'd0);

        // Accumulate from a cleared P
        rstp = 1'b1;
        step();
        rstp = 1'b0;
        x_sel = 2'd1; z_sel = 2'd2; m = 36'd3; cin = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("acc_p", 64'(p), 64'(3 * i));
        end
        cep = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("acc_hold", 64'(p), 64'd12);
        end
        cep = 1'b1;

        // Wrap-around into carry-out
        z_sel = 2'd3; c = 48'hFFFF_FFFF_FFFF; x_sel = 2'd1; m = 36'd1; cin = 1'b0;
        step();
        chk("wrap_p", 64'(p), 64'd0);
        chk("wrap_co", 64'(carryout), 64'd1);
`ifdef ACC_OVF_DETECT_EN
        x_sel = 2'd0;
        step();
        z_sel = 2'd2; x_sel = 2'd1; m = 36'd1;
        step();
        chk("ovf_set", 64'(ovf), 64'd1);
        z_sel = 2'd3; c = 48'd1; x_sel = 2'd0;
        step();
        chk("ovf_hold", 64'(ovf), 64'd1);
`endif

        // Subtract, non-negative and negative results
        sub = 1'b1; z_sel = 2'd3; c = 48'd20; x_sel = 2'd3; dab = 48'd7; cin = 1'b1;
        step();
        chk("sub_p", 64'(p), 64'd12);
        chk("sub_co", 64'(carryout), 64'd0);
        c = 48'd5;
        step();
        chk("subneg_p", 64'(p), 64'hFFFF_FFFF_FFFD);
        chk("subneg_co", 64'(carryout), 64'd1);

        // Sync reset mid-accumulation wins over enable
        sub = 1'b0; x_sel = 2'd1; z_sel = 2'd2; m = 36'd9; cin = 1'b0;
        step();
        step();
        rstp = 1'b1;
        step();
        chk("rstp_p", 64'(p), 64'd0);
        rstp = 1'b0;
        step();
        chk("rstp_reload", 64'(p), 64'd9);

        // Async reset pulse between edges
        z_sel = 2'd3; c = 48'hFFFF_FFFF_FFFF; x_sel = 2'd1; m = 36'd2;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        m_p = '0; m_co = 1'b0;
`ifdef ACC_OVF_DETECT_EN
        m_ovf = 1'b0; m_ovf_c = 1'b0;
        chk("arst_ovf", 64'(ovf), 64'd0);
`endif
        chk("arst_p", 64'(p), 64'd0);
        chk("arst_co", 64'(carryout), 64'd0);
        #1;
        rst_n = 1'b1;

        // Combinational instance follows inputs within the cycle; P reads as 0
        step();
        x_sel = 2'd2; z_sel = 2'd3; c = 48'd100; cin = 1'b1; sub = 1'b0;
        #1;
        chk("comb_fb_p", 64'(p_c), 64'd101);
        c = 48'hFFFF_FFFF_FFFF;
        #1;
        chk("comb_wrap_p", 64'(p_c), 64'd0);
        chk("comb_wrap_co", 64'(co_c), 64'd1);
        chk("comb_wrap_cof", 64'(cof_c), 64'd1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            x_sel     = 2'($urandom_range(0, 3));
            z_sel     = 2'($urandom_range(0, 3));
            sub       = 1'($urandom_range(0, 1));
            cin       = 1'($urandom_range(0, 1));
            cep       = ($urandom_range(0, 3) != 0);
            cecarryin = ($urandom_range(0, 3) != 0);
            rstp      = ($urandom_range(0, 19) == 0);
            m         = 36'({$urandom(), $urandom()});
            dab       = 48'({$urandom(), $urandom()});
            c         = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFF
                                                    : 48'({$urandom(), $urandom()});
            pcin      = 48'({$urandom(), $urandom()});
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
